// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle for sram_arbiter: two ports (A, B), each
// with a request/operand group driven by the requester and a done/rdata return.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_done, a_rdata, b_done, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_done, a_rdata, b_done, b_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter sequencing each grant into a fixed
// IDLE/ADDR/STROBE/HOLD access on a single asynchronous 16-bit SRAM.
module sram_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [DATA_W-1:0] io_SRAM_DQ,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_LB_N,
  output logic              o_SRAM_UB_N
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADDR   = 2'd1;
  localparam logic [1:0] ST_STROBE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [1:0]        state_reg;
  logic              grant_reg;
  logic              last_grant_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              dq_oe_reg;
  logic              we_n_reg;
  logic              oe_n_reg;

  logic [1:0]        req;
  logic [1:0]        req_we;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic              grant_next;

  assign req          = {bus.b_req, bus.a_req};
  assign req_we       = {bus.b_we, bus.a_we};
  assign req_addr[0]  = bus.a_addr;
  assign req_addr[1]  = bus.b_addr;
  assign req_wdata[0] = bus.a_wdata;
  assign req_wdata[1] = bus.b_wdata;

  // B wins only when A is idle, or when both request and A had the last grant.
  always_comb begin
    grant_next = PORT_A;
    if (req[1] && (!req[0] || last_grant_reg == PORT_A)) begin
      grant_next = PORT_B;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= PORT_A;
      last_grant_reg <= PORT_B;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      dq_oe_reg      <= 1'b0;
      we_n_reg       <= 1'b1;
      oe_n_reg       <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|req) begin
            state_reg      <= ST_ADDR;
            grant_reg      <= grant_next;
            last_grant_reg <= grant_next;
            we_reg         <= req_we[grant_next];
            addr_reg       <= req_addr[grant_next];
            wdata_reg      <= req_wdata[grant_next];
            // Writes drive DQ from ADDR onwards for setup; reads enable OE at once.
            dq_oe_reg      <= req_we[grant_next];
            oe_n_reg       <= req_we[grant_next];
            we_n_reg       <= 1'b1;
          end
        end
        ST_ADDR: begin
          state_reg <= ST_STROBE;
          we_n_reg  <= !we_reg;
          oe_n_reg  <= we_reg;
        end
        ST_STROBE: begin
          state_reg <= ST_HOLD;
          we_n_reg  <= 1'b1;
          oe_n_reg  <= 1'b1;
        end
        default: begin
          // HOLD keeps data on the bus one cycle past the WE_N rising edge.
          state_reg <= ST_IDLE;
          dq_oe_reg <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic              done_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              owns_strobe;

    assign owns_strobe = (state_reg == ST_STROBE) && (int'(grant_reg) == gi);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        done_reg  <= 1'b0;
        rdata_reg <= '0;
      end else begin
        done_reg <= owns_strobe;
        if (owns_strobe && !we_reg) begin
          rdata_reg <= io_SRAM_DQ;
        end
      end
    end
  end

  assign bus.a_done  = g_port[0].done_reg;
  assign bus.a_rdata = g_port[0].rdata_reg;
  assign bus.b_done  = g_port[1].done_reg;
  assign bus.b_rdata = g_port[1].rdata_reg;

  assign o_SRAM_ADDR = addr_reg;
  assign io_SRAM_DQ  = dq_oe_reg ? wdata_reg : {DATA_W{1'bz}};
  assign o_SRAM_WE_N = we_n_reg;
  assign o_SRAM_OE_N = oe_n_reg;
  assign o_SRAM_CE_N = 1'b0;
  assign o_SRAM_LB_N = 1'b0;
  assign o_SRAM_UB_N = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scenario bench for sram_arbiter: behavioural SRAM with pull-ups on DQ,
// done-pulse monitor feeding an observed queue checked against expectations.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam logic [DW-1:0] BUS_REL = 16'hFFFF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  wire  [DW-1:0] dq;
  logic [AW-1:0] sram_addr;
  logic          we_n, ce_n, oe_n, lb_n, ub_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus),
    .o_SRAM_ADDR (sram_addr),
    .io_SRAM_DQ  (dq),
    .o_SRAM_WE_N (we_n),
    .o_SRAM_CE_N (ce_n),
    .o_SRAM_OE_N (oe_n),
    .o_SRAM_LB_N (lb_n),
    .o_SRAM_UB_N (ub_n)
  );

  // Behavioural SRAM: a released bus floats high through the pull-ups.
  logic [DW-1:0] mem [64];
  always @(posedge clk) if (!we_n) mem[sram_addr[5:0]] <= dq;
  assign dq = (!oe_n && we_n) ? mem[sram_addr[5:0]] : {DW{1'bz}};
  for (genvar gi = 0; gi < DW; gi++) begin : g_pu
    pullup (dq[gi]);
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            port;
    bit            rd;
    logic [DW-1:0] data;
    int            cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.a_done) obs_q.push_back('{0, 1'b0, bus.a_rdata, cyc});
    if (rst_n && bus.b_done) obs_q.push_back('{1, 1'b0, bus.b_rdata, cyc});
  end

  task automatic drive_port(input int port, input logic req, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({we_n, oe_n, ce_n, lb_n, ub_n, bus.a_done, bus.b_done} !== 7'b1100000)
      $display("FAIL reset_strobes: got %b expected 1100000",
               {we_n, oe_n, ce_n, lb_n, ub_n, bus.a_done, bus.b_done});
    else checks += 0;
    if ({we_n, oe_n, ce_n, lb_n, ub_n, bus.a_done, bus.b_done} !== 7'b1100000) errors++;
    checks++;
    if (sram_addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0", sram_addr);
    end
    checks++;
    if (dq !== BUS_REL) begin
      errors++; $display("FAIL reset_dq: got %h expected %h (released)", dq, BUS_REL);
    end
    checks++;
    if ({bus.a_rdata, bus.b_rdata} !== '0) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.a_rdata, bus.b_rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    txn_t o, e;
    logic [DW-1:0] exp_dq;
    @(posedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 20'h00010, 16'hBEEF);
    exp_q.push_back('{0, 1'b0, 16'hBEEF, 0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({we_n, oe_n} !== {(k == 2) ? 1'b0 : 1'b1, 1'b1}) begin
        errors++; $display("FAIL wr_strobes k=%0d: got we_n/oe_n=%b%b", k, we_n, oe_n);
      end
      exp_dq = (k >= 1 && k <= 3) ? 16'hBEEF : BUS_REL;
      checks++;
      if (dq !== exp_dq) begin
        errors++; $display("FAIL wr_dq k=%0d: got %h expected %h", k, dq, exp_dq);
      end
      checks++;
      if (bus.a_done !== (k == 3)) begin
        errors++; $display("FAIL wr_done k=%0d: got %b expected %b", k, bus.a_done, k == 3);
      end
      if (k == 3) begin
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
      end
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL wr_sb_count: got %0d dones expected 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.port != e.port) begin
        errors++; $display("FAIL wr_sb_port: got %0d expected %0d", o.port, e.port);
      end
      checks++;
      if (mem[16] !== e.data) begin
        errors++; $display("FAIL wr_mem: got %h expected %h", mem[16], e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_read_back();
    txn_t o, e;
    logic [DW-1:0] exp_dq;
    @(posedge clk); #1;
    drive_port(1, 1'b1, 1'b0, 20'h00010, 16'h1234);
    exp_q.push_back('{1, 1'b1, 16'hBEEF, 0});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({we_n, oe_n} !== {1'b1, (k == 1 || k == 2) ? 1'b0 : 1'b1}) begin
        errors++; $display("FAIL rd_strobes k=%0d: got we_n/oe_n=%b%b", k, we_n, oe_n);
      end
      exp_dq = (k == 1 || k == 2) ? 16'hBEEF : BUS_REL;
      checks++;
      if (dq !== exp_dq) begin
        errors++; $display("FAIL rd_dq k=%0d: got %h expected %h", k, dq, exp_dq);
      end
      checks++;
      if ({bus.a_done, bus.b_done} !== {1'b0, k == 3}) begin
        errors++; $display("FAIL rd_done k=%0d: got a/b=%b%b", k, bus.a_done, bus.b_done);
      end
      if (k == 3) begin
        @(posedge clk); #1;
        drive_port(1, 1'b0, 1'b0, '0, '0);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.b_rdata !== 16'hBEEF) begin
      errors++; $display("FAIL rd_hold: got %h expected BEEF", bus.b_rdata);
    end
    checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL rd_sb_count: got %0d dones expected 1", obs_q.size());
    end else begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.port != e.port || o.data !== e.data) begin
        errors++; $display("FAIL rd_sb: got port %0d data %h expected port %0d data %h",
                           o.port, o.data, e.port, e.data);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_conflict();
    txn_t o, e;
    int n_done, n_a, prev;
    pulse_reset();
    @(posedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 20'h00020, 16'h2222);
    drive_port(1, 1'b1, 1'b0, 20'h00010, 16'h0000);
    for (int i = 0; i < 8; i++) exp_q.push_back('{i % 2, (i % 2) == 1, 16'hBEEF, 0});
    n_done = 0;
    for (int c = 0; c < 60 && n_done < 8; c++) begin
      @(negedge clk);
      if (bus.a_done || bus.b_done) n_done++;
      if (n_done == 8) begin
        @(posedge clk); #1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
      end
    end
    #1;
    checks++;
    if (obs_q.size() != 8) begin
      errors++; $display("FAIL cf_count: got %0d dones expected 8", obs_q.size());
    end
    n_a = 0; prev = 0;
    for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      if (o.port == 0) n_a++;
      checks++;
      if (o.port != e.port) begin
        errors++; $display("FAIL cf_order[%0d]: got port %0d expected %0d", i, o.port, e.port);
      end
      if (i > 0) begin
        checks++;
        if (o.cyc - prev != 4) begin
          errors++; $display("FAIL cf_spacing[%0d]: got %0d cycles expected 4", i, o.cyc - prev);
        end
      end
      if (e.rd) begin
        checks++;
        if (o.data !== e.data) begin
          errors++; $display("FAIL cf_rdata[%0d]: got %h expected %h", i, o.data, e.data);
        end
      end
      prev = o.cyc;
    end
    checks++;
    if (n_a != 4) begin
      errors++; $display("FAIL cf_share: got %0d A grants expected 4", n_a);
    end
    checks++;
    if (mem[32] !== 16'h2222) begin
      errors++; $display("FAIL cf_mem: got %h expected 2222", mem[32]);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    txn_t o;
    logic [DW-1:0] exp_dq;
    int ph, j, prev;
    @(posedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 20'd0, 16'h1111);
    exp_q.push_back('{0, 1'b0, 16'h1111, 0});
    for (int k = 0; k < 16; k++) begin
      ph = k % 4; j = k / 4;
      @(negedge clk);
      exp_dq = (ph == 0) ? BUS_REL : 16'(16'h1111 + j);
      checks++;
      if (dq !== exp_dq) begin
        errors++; $display("FAIL b2b_dq k=%0d: got %h expected %h", k, dq, exp_dq);
      end
      checks++;
      if (bus.a_done !== (ph == 3)) begin
        errors++; $display("FAIL b2b_done k=%0d: got %b expected %b", k, bus.a_done, ph == 3);
      end
      if (ph == 3) begin
        @(posedge clk); #1;
        if (j < 3) begin
          drive_port(0, 1'b1, 1'b1, 20'(j + 1), 16'(16'h1111 + j + 1));
          exp_q.push_back('{0, 1'b0, 16'(16'h1111 + j + 1), 0});
        end else begin
          drive_port(0, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        errors++; $display("FAIL b2b_sb[%0d]: got no done expected one", i);
      end else begin
        o = obs_q.pop_front();
        if (i > 0 && o.cyc - prev != 4) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, o.cyc - prev);
        end
        prev = o.cyc;
        checks++;
        if (mem[i] !== exp_q[0].data) begin
          errors++; $display("FAIL b2b_mem[%0d]: got %h expected %h", i, mem[i], exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] old5;
    old5 = mem[5];
    @(posedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 20'd5, 16'h5555);
    repeat (3) @(negedge clk);
    checks++;
    if (we_n !== 1'b0) begin
      errors++; $display("FAIL rm_strobe: got we_n=%b expected 0", we_n);
    end
    #1;
    rst_n = 1'b0;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if ({we_n, oe_n} !== 2'b11 || dq !== BUS_REL) begin
      errors++; $display("FAIL rm_abort: got we_n/oe_n=%b%b dq=%h expected 11/%h",
                         we_n, oe_n, dq, BUS_REL);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({we_n, oe_n, ce_n, lb_n, ub_n, bus.a_done, bus.b_done} !== 7'b1100000 ||
        sram_addr !== '0 || dq !== BUS_REL) begin
      errors++; $display("FAIL rm_outputs: got strobes %b addr %h dq %h",
                         {we_n, oe_n, ce_n, lb_n, ub_n, bus.a_done, bus.b_done}, sram_addr, dq);
    end
    checks++;
    if ({bus.a_rdata, bus.b_rdata} !== '0) begin
      errors++; $display("FAIL rm_rdata: got %h/%h expected 0/0", bus.a_rdata, bus.b_rdata);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL rm_nodone: got %0d dones expected 0", obs_q.size());
    end
    checks++;
    if (mem[5] !== old5) begin
      errors++; $display("FAIL rm_mem: got %h expected %h", mem[5], old5);
    end
    @(posedge clk); #1;
    drive_port(0, 1'b1, 1'b1, 20'd5, 16'h5A5A);
    exp_q.push_back('{0, 1'b0, 16'h5A5A, 0});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.a_done !== (k == 3)) begin
        errors++; $display("FAIL rm_redo_done k=%0d: got %b expected %b", k, bus.a_done, k == 3);
      end
    end
    @(posedge clk); #1;
    drive_port(0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (obs_q.size() != 1 || mem[5] !== exp_q[0].data) begin
      errors++; $display("FAIL rm_redo: got %0d dones mem %h expected 1 and %h",
                         obs_q.size(), mem[5], exp_q[0].data);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_idle_bus();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      checks++;
      if ({we_n, oe_n, bus.a_done, bus.b_done} !== 4'b1100 || dq !== BUS_REL) begin
        errors++; $display("FAIL idle k=%0d: got we_n/oe_n/done=%b dq=%h expected 1100/%h",
                           k, {we_n, oe_n, bus.a_done, bus.b_done}, dq, BUS_REL);
      end
    end
  endtask

  initial begin
    drive_port(0, 1'b0, 1'b0, '0, '0);
    drive_port(1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_write();
    test_read_back();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_idle_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
